adc_in_router: RTL and testbench

- 2-to-8 registered router (demultiplexer) from the two Red Pitaya ADC channels to eight 14-bit processing-chain inputs.
- Each output independently selects ADC A, ADC B, hold or zero, and updates only on a valid sample from its source.
- On every select change, the affected output is blanked for a programmable settling window, so feedback paths never see a mid-switch glitch.
- Sits between the ADC capture logic and the feedback/filter channels; the mirror of the 8-to-2 DAC output mux.

---
 rtl/adc_in_router.sv | 78 +++++++
 tb/tb_adc_in_router.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/adc_in_router.sv
// adc_in_router: registered 2-to-8 ADC sample router with per-output select blanking
module adc_in_router #(
   parameter int WIDTH        = 14,
   parameter int BLANK_CYCLES = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] in0_i,
   input  logic             in0_valid_i,
   input  logic [WIDTH-1:0] in1_i,
   input  logic             in1_valid_i,
   input  logic [15:0]      sel_i,
   output logic [WIDTH-1:0] out0_o,
   output logic [WIDTH-1:0] out1_o,
   output logic [WIDTH-1:0] out2_o,
   output logic [WIDTH-1:0] out3_o,
   output logic [WIDTH-1:0] out4_o,
   output logic [WIDTH-1:0] out5_o,
   output logic [WIDTH-1:0] out6_o,
   output logic [WIDTH-1:0] out7_o,
   output logic [7:0]       valid_o,
   output logic [7:0]       settled_o
);
   localparam int CW = BLANK_CYCLES > 0 ? $clog2(BLANK_CYCLES + 1) : 1;
   localparam logic [CW-1:0] LOAD = CW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
   logic [WIDTH-1:0] out_w [8];
   assign out0_o = out_w[0];
   assign out1_o = out_w[1];
   assign out2_o = out_w[2];
   assign out3_o = out_w[3];
   assign out4_o = out_w[4];
   assign out5_o = out_w[5];
   assign out6_o = out_w[6];
   assign out7_o = out_w[7];
   for (genvar k = 0; k < 8; k++) begin : g_out
      logic [1:0]       sel_q;
      logic [1:0]       sel_n;
      logic [CW-1:0]    cnt_q;
      logic [WIDTH-1:0] out_q;
      logic             val_q;
      logic             set_q;
      logic             chg;
      assign sel_n = sel_i[2*k +: 2];
      assign chg   = sel_n != sel_q;
      assign out_w[k]     = out_q;
      assign valid_o[k]   = val_q;
      assign settled_o[k] = set_q;
      // cnt_q holds the blanked edges still to come after the current one
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            sel_q <= '0;
            cnt_q <= '0;
            out_q <= '0;
            val_q <= 1'b0;
            set_q <= 1'b1;
         end else if (chg && BLANK_CYCLES > 0) begin
            sel_q <= sel_n;
            cnt_q <= LOAD;
            out_q <= '0;
            val_q <= 1'b0;
            set_q <= 1'b0;
         end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
            out_q <= '0;
            val_q <= 1'b0;
            set_q <= 1'b0;
         end else begin
            sel_q <= sel_n;
            set_q <= 1'b1;
            out_q <= sel_n == 2'd3                  ? '0 :
                     (sel_n == 2'd0 && in0_valid_i) ? in0_i :
                     (sel_n == 2'd1 && in1_valid_i) ? in1_i : out_q;
            val_q <= sel_n == 2'd3 || (sel_n == 2'd0 && in0_valid_i) ||
                     (sel_n == 2'd1 && in1_valid_i);
         end
      end
   end
endmodule

// File: tb/tb_adc_in_router.sv
// tb_adc_in_router: directed vectors into a scoreboard, checked for BLANK_CYCLES=4 and 0
module tb_adc_in_router;
   typedef struct {
      int           d;
      logic [111:0] eo;
      logic [7:0]   ev;
      logic [7:0]   es;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [13:0] in0 = '0;
   logic [13:0] in1 = '0;
   logic        v0 = 1'b0;
   logic        v1 = 1'b0;
   logic [15:0] sel = '0;
   logic [13:0] a_o [8];
   logic [13:0] b_o [8];
   logic [7:0]  a_v, a_s, b_v, b_s;
   exp_t        q[$];
   exp_t        e;
   int          applied = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   adc_in_router #(.WIDTH(14), .BLANK_CYCLES(4)) dut0 (
      .clk_i(clk), .rst_i(rst), .in0_i(in0), .in0_valid_i(v0), .in1_i(in1), .in1_valid_i(v1),
      .sel_i(sel), .out0_o(a_o[0]), .out1_o(a_o[1]), .out2_o(a_o[2]), .out3_o(a_o[3]),
      .out4_o(a_o[4]), .out5_o(a_o[5]), .out6_o(a_o[6]), .out7_o(a_o[7]),
      .valid_o(a_v), .settled_o(a_s));

   adc_in_router #(.WIDTH(14), .BLANK_CYCLES(0)) dut1 (
      .clk_i(clk), .rst_i(rst), .in0_i(in0), .in0_valid_i(v0), .in1_i(in1), .in1_valid_i(v1),
      .sel_i(sel), .out0_o(b_o[0]), .out1_o(b_o[1]), .out2_o(b_o[2]), .out3_o(b_o[3]),
      .out4_o(b_o[4]), .out5_o(b_o[5]), .out6_o(b_o[6]), .out7_o(b_o[7]),
      .valid_o(b_v), .settled_o(b_s));

   function automatic logic [111:0] mk3(input logic [13:0] base, input logic [7:0] m1,
                                        input logic [13:0] v1, input logic [7:0] m2,
                                        input logic [13:0] v2);
      logic [111:0] r;
      for (int k = 0; k < 8; k++) r[k*14 +: 14] = m2[k] ? v2 : m1[k] ? v1 : base;
      return r;
   endfunction

   // monitor: every entry queued before an edge describes the state right after it
   always @(posedge clk) begin
      #1;
      while (q.size() > 0) begin
         logic [111:0] ao;
         logic [7:0]   av, as;
         logic         bad;
         e = q.pop_front();
         for (int k = 0; k < 8; k++) ao[k*14 +: 14] = e.d == 0 ? a_o[k] : b_o[k];
         av = e.d == 0 ? a_v : b_v;
         as = e.d == 0 ? a_s : b_s;
         bad = 1'b0;
         applied++;
         if (ao !== e.eo) begin
            bad = 1'b1;
            $display("FAIL outs dut%0d @%0t: got %h expected %h", e.d, $time, ao, e.eo);
         end
         if (av !== e.ev) begin
            bad = 1'b1;
            $display("FAIL valid_o dut%0d @%0t: got %h expected %h", e.d, $time, av, e.ev);
         end
         if (as !== e.es) begin
            bad = 1'b1;
            $display("FAIL settled_o dut%0d @%0t: got %h expected %h", e.d, $time, as, e.es);
         end
         if (bad) errors++;
      end
   end

   task automatic step(input logic r, input logic [15:0] s, input logic [13:0] a,
                       input logic va, input logic [13:0] b, input logic vb,
                       input logic [111:0] eo, input logic [7:0] ev, input logic [7:0] es);
      @(negedge clk);
      rst = r;
      sel = s;
      in0 = a;
      v0  = va;
      in1 = b;
      v1  = vb;
      q.push_back('{0, eo, ev, es});
   endtask

   task automatic exp1(input logic [111:0] eo, input logic [7:0] ev, input logic [7:0] es);
      q.push_back('{1, eo, ev, es});
   endtask

   initial begin
      logic [13:0] a, b;
      // reset holds everything cleared while inputs toggle
      step(1, 16'h0000, 14'h0123, 1, 14'h3F00, 1, '0, 8'h00, 8'hFF);
      exp1('0, 8'h00, 8'hFF);
      step(1, 16'h0000, 14'h3F00, 1, 14'h0123, 1, '0, 8'h00, 8'hFF);
      step(0, 16'h0000, 14'h0123, 1, 14'h3F00, 1, mk3(14'h0123, 0, 0, 0, 0), 8'hFF, 8'hFF);
      exp1(mk3(14'h0123, 0, 0, 0, 0), 8'hFF, 8'hFF);
      // out3 -> in1: four blank edges, then routed
      for (int i = 0; i < 4; i++)
         step(0, 16'h0040, 14'h0123, 1, 14'h3F00, 1, mk3(14'h0123, 0, 0, 8'h08, 0), 8'hF7, 8'hF7);
      step(0, 16'h0040, 14'h0123, 1, 14'h3F00, 1, mk3(14'h0123, 8'h08, 14'h3F00, 0, 0), 8'hFF, 8'hFF);
      step(0, 16'h0040, 14'h0123, 1, 14'h0AAA, 0, mk3(14'h0123, 8'h08, 14'h3F00, 0, 0), 8'hF7, 8'hFF);
      // out5 0->1 while the rest keep streaming
      for (int i = 0; i < 5; i++) begin
         a = 14'h0011 + 14'(i);
         b = 14'h2222 + 14'(i);
         if (i < 4) step(0, 16'h0440, a, 1, b, 1, mk3(a, 8'h08, b, 8'h20, 0), 8'hDF, 8'hDF);
         else       step(0, 16'h0440, a, 1, b, 1, mk3(a, 8'h28, b, 0, 0), 8'hFF, 8'hFF);
      end
      // out2 changes at E0 and back at E2: window restarts, first update at E6
      for (int i = 0; i < 7; i++) begin
         a = 14'h0100 + 14'(i);
         b = 14'h0200 + 14'(i);
         step(0, i < 2 ? 16'h0450 : 16'h0440, a, 1, b, 1,
              mk3(a, 8'h28, b, 8'h04, i == 6 ? a : 14'h0), i == 6 ? 8'hFF : 8'hFB,
              i == 6 ? 8'hFF : 8'hFB);
         exp1(mk3(a, i < 2 ? 8'h2C : 8'h28, b, 0, 0), 8'hFF, 8'hFF);
      end
      // hold: blanked output holds zero; unblanked one freezes 1555
      step(0, 16'h0440, 14'h1555, 1, 14'h0300, 1, mk3(14'h1555, 8'h28, 14'h0300, 0, 0), 8'hFF, 8'hFF);
      exp1(mk3(14'h1555, 8'h28, 14'h0300, 0, 0), 8'hFF, 8'hFF);
      for (int i = 0; i < 5; i++) begin
         a = 14'h0400 + 14'(i);
         b = 14'h0500 + 14'(i);
         step(0, 16'h0448, a, 1, b, 1, mk3(a, 8'h28, b, 8'h02, 0), 8'hFD, i < 4 ? 8'hFD : 8'hFF);
         exp1(mk3(a, 8'h28, b, 8'h02, 14'h1555), 8'hFD, 8'hFF);
      end
      // zero: valid every cycle once settled
      for (int i = 0; i < 6; i++) begin
         a = 14'h0600 + 14'(i);
         b = 14'h0700 + 14'(i);
         step(0, 16'h044C, a, 1, b, 1, mk3(a, 8'h28, b, 8'h02, 0), i < 4 ? 8'hFD : 8'hFF,
              i < 4 ? 8'hFD : 8'hFF);
         exp1(mk3(a, 8'h28, b, 8'h02, 0), 8'hFF, 8'hFF);
      end
      // out7 -> zero, reset lands at E2 of its window
      for (int i = 0; i < 2; i++) begin
         a = 14'h0800 + 14'(i);
         b = 14'h0900 + 14'(i);
         step(0, 16'hC44C, a, 1, b, 1, mk3(a, 8'h28, b, 8'h82, 0), 8'h7F, 8'h7F);
         exp1(mk3(a, 8'h28, b, 8'h82, 0), 8'hFF, 8'hFF);
      end
      step(1, 16'hC44C, 14'h0855, 1, 14'h0955, 1, '0, 8'h00, 8'hFF);
      exp1('0, 8'h00, 8'hFF);
      // nonzero sel at release: every non-zero-select output blanks again
      for (int i = 0; i < 5; i++) begin
         a = 14'h0A00 + 14'(i);
         b = 14'h3B00 + 14'(i);
         if (i < 4) step(0, 16'hC44C, a, 1, b, 1, mk3(a, 0, 0, 8'hAA, 0), 8'h55, 8'h55);
         else       step(0, 16'hC44C, a, 1, b, 1, mk3(a, 8'h28, b, 8'h82, 0), 8'hFF, 8'hFF);
         exp1(mk3(a, 8'h28, b, 8'h82, 0), 8'hFF, 8'hFF);
      end
      @(negedge clk);
      @(negedge clk);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
      $finish;
   end
endmodule
